// File: rtl/wb_pipe.sv
// Write-back stage: commits ALU results or load data to the register file, and holds a load in WAIT until it is acknowledged, flushed or timed out.
// Define WB_LOAD_ALIGN_EN to enable byte/halfword load selection with sign/zero extension.
module wb_pipe #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic              i_wr_en,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  logic [XLEN-1:0]   i_rd,
  input  logic              i_opcode_load,
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_addr_lsb,
  input  logic              i_mem_ack,
  input  logic [XLEN-1:0]   i_mem_loaded,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_wr_en,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic [XLEN-1:0]   o_rd,
  output logic              o_ce,
  output logic              o_err
);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [REG_AW-1:0] rd_addr_q;
  logic              wr_en_q;
  logic              go_wait;
  logic [XLEN-1:0]   ld_now, ld_wait;

  assign o_stall = (state == WAIT);
  assign go_wait = (state == IDLE) && i_ce && !i_flush && i_opcode_load && !i_mem_ack;

`ifdef WB_LOAD_ALIGN_EN
  logic [2:0] funct3_q;
  logic [1:0] addr_lsb_q;

  // Halfwords are picked by the upper offset bit; lsb[0] does not shift them.
  function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] w,
                                          input logic [2:0] f3,
                                          input logic [1:0] lsb);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lsb, 3'b000});
    h = 16'(w >> {lsb[1], 4'b0000});
    case (f3)
      3'b000:  fmt = {{(XLEN-8){b[7]}}, b};
      3'b001:  fmt = {{(XLEN-16){h[15]}}, h};
      3'b100:  fmt = {{(XLEN-8){1'b0}}, b};
      3'b101:  fmt = {{(XLEN-16){1'b0}}, h};
      default: fmt = w;
    endcase
  endfunction

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      funct3_q   <= '0;
      addr_lsb_q <= '0;
    end else if (go_wait) begin
      funct3_q   <= i_funct3;
      addr_lsb_q <= i_addr_lsb;
    end

  assign ld_now  = fmt(i_mem_loaded, i_funct3, i_addr_lsb);
  assign ld_wait = fmt(i_mem_loaded, funct3_q, addr_lsb_q);
`else
  logic unused_fmt;
  assign unused_fmt = ^{i_funct3, i_addr_lsb};
  assign ld_now     = i_mem_loaded;
  assign ld_wait    = i_mem_loaded;
`endif

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      o_wr_en   <= 1'b0;
      o_ce      <= 1'b0;
      o_err     <= 1'b0;
      o_rd      <= '0;
      o_rd_addr <= '0;
    end else begin
      o_wr_en <= 1'b0;
      o_ce    <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (go_wait) begin
            state     <= WAIT;
            cnt       <= '0;
            rd_addr_q <= i_rd_addr;
            wr_en_q   <= i_wr_en;
          end else if (i_ce && !i_flush) begin
            o_ce      <= 1'b1;
            o_wr_en   <= i_wr_en && (i_rd_addr != '0);
            o_rd_addr <= i_rd_addr;
            o_rd      <= i_opcode_load ? ld_now : i_rd;
          end
        end
        WAIT: begin
          // Flush has priority over both ack and timeout.
          if (i_flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (i_mem_ack) begin
            state     <= IDLE;
            cnt       <= '0;
            o_ce      <= 1'b1;
            o_wr_en   <= wr_en_q && (rd_addr_q != '0);
            o_rd_addr <= rd_addr_q;
            o_rd      <= ld_wait;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            o_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wb_pipe.sv
// Scoreboard bench for wb_pipe: transaction-level driver predicts each retire/error, a monitor pops and compares.
module tb_wb_pipe;
  localparam int XLEN = 32, REG_AW = 5, T = 15;

  logic              i_clk = 1'b0, i_rst;
  logic              i_ce, i_wr_en, i_opcode_load, i_mem_ack, i_flush;
  logic [REG_AW-1:0] i_rd_addr;
  logic [XLEN-1:0]   i_rd, i_mem_loaded;
  logic [2:0]        i_funct3;
  logic [1:0]        i_addr_lsb;
  logic              o_stall, o_wr_en, o_ce, o_err;
  logic [REG_AW-1:0] o_rd_addr;
  logic [XLEN-1:0]   o_rd;

  wb_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .TIMEOUT_CYC(T)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_wr_en(i_wr_en),
    .i_rd_addr(i_rd_addr), .i_rd(i_rd), .i_opcode_load(i_opcode_load),
    .i_funct3(i_funct3), .i_addr_lsb(i_addr_lsb), .i_mem_ack(i_mem_ack),
    .i_mem_loaded(i_mem_loaded), .i_flush(i_flush), .o_stall(o_stall),
    .o_wr_en(o_wr_en), .o_rd_addr(o_rd_addr), .o_rd(o_rd), .o_ce(o_ce), .o_err(o_err));

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic              err;
    logic              wr;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } exp_t;

  exp_t sbq[$];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference load formatting from the ISA rules: pick a byte/halfword, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lsb);
`ifdef WB_LOAD_ALIGN_EN
    int unsigned b, h;
    b = (w >> (8 * lsb)) & 32'hFF;
    h = (w >> (16 * (lsb / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
`else
    if (f3 == 3'd7 && lsb == 2'd3) return w;
    return w;
`endif
  endfunction

  initial forever begin
    @(negedge i_clk);
    if (o_ce || o_err || o_wr_en) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious: ce=%b wr=%b err=%b rd=%h with nothing expected (t=%0t)",
                 o_ce, o_wr_en, o_err, o_rd, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ce", XLEN'(o_ce), XLEN'(!e.err));
        chk("err", XLEN'(o_err), XLEN'(e.err));
        chk("wr_en", XLEN'(o_wr_en), XLEN'(e.wr));
        if (!e.err) begin
          chk("rd_addr", XLEN'(o_rd_addr), XLEN'(e.addr));
          chk("rd", o_rd, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic idle_in();
    i_ce = 0; i_opcode_load = 0; i_mem_ack = 0; i_flush = 0; i_wr_en = 0;
  endtask

  task automatic do_alu(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d, input logic we, input logic fl);
    i_ce = 1; i_opcode_load = 0; i_wr_en = we; i_rd_addr = a; i_rd = d; i_flush = fl;
    i_mem_ack = 1'($urandom); i_mem_loaded = $urandom;
    if (!fl) sbq.push_back('{err: 1'b0, wr: we && (a != 0), addr: a, data: d});
    step();
    idle_in();
  endtask

  // d: ack delay in WAIT cycles (0 = ack at accept, >T = never); fk: flush cycle (-1 none, 0 at accept).
  task automatic do_load(input logic [REG_AW-1:0] a, input logic we, input logic [2:0] f3,
                         input logic [1:0] lsb, input logic [XLEN-1:0] w, input int d, input int fk);
    exp_t ok;
    ok = '{err: 1'b0, wr: we && (a != 0), addr: a, data: ref_load(w, f3, lsb)};
    i_ce = 1; i_opcode_load = 1; i_wr_en = we; i_rd_addr = a; i_funct3 = f3; i_addr_lsb = lsb;
    i_rd = $urandom; i_mem_ack = (d == 0); i_mem_loaded = (d == 0) ? w : $urandom; i_flush = (fk == 0);
    if (fk == 0 || d == 0) begin
      if (fk != 0) sbq.push_back(ok);
      step();
      idle_in();
      chk("stall_idle_accept", XLEN'(o_stall), 0);
      return;
    end
    step();
    for (int k = 1; k <= T; k++) begin
      chk("stall_wait", XLEN'(o_stall), 1);
      i_ce = 1'($urandom); i_rd_addr = REG_AW'($urandom); i_rd = $urandom; i_wr_en = 1'($urandom);
      i_opcode_load = 1'($urandom); i_funct3 = 3'($urandom); i_addr_lsb = 2'($urandom);
      i_mem_ack = (k == d); i_mem_loaded = (k == d) ? w : $urandom; i_flush = (k == fk);
      if (k == fk) ;
      else if (k == d) sbq.push_back(ok);
      else if (k == T) sbq.push_back('{err: 1'b1, wr: 1'b0, addr: '0, data: '0});
      step();
      if (k == fk || k == d) break;
    end
    idle_in();
    chk("stall_after", XLEN'(o_stall), 0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_wr"}, XLEN'(o_wr_en), 0);
    chk({nm, "_ce"}, XLEN'(o_ce), 0);
    chk({nm, "_err"}, XLEN'(o_err), 0);
    chk({nm, "_stall"}, XLEN'(o_stall), 0);
    chk({nm, "_rd"}, o_rd, 0);
    chk({nm, "_addr"}, XLEN'(o_rd_addr), 0);
  endtask

  initial begin
    i_rst = 1; idle_in();
    i_rd_addr = '0; i_rd = '0; i_funct3 = '0; i_addr_lsb = '0; i_mem_loaded = '0;
    #3 chk_reset_vals("reset");
    step(); step();
    i_rst = 0;
    step();

    // Directed ALU write
    do_alu(5, 32'h1234_5678, 1, 0);
    chk("alu_wr", XLEN'(o_wr_en), 1);
    chk("alu_addr", XLEN'(o_rd_addr), 5);
    chk("alu_rd", o_rd, 32'h1234_5678);
    step();
    chk("alu_pulse", XLEN'(o_ce), 0);
    chk("rd_hold", o_rd, 32'h1234_5678);

    // Load acked on the third WAIT cycle
    do_load(7, 1, 3'b010, 0, 32'hDEAD_BEEF, 3, -1);
    chk("ld_late_rd", o_rd, 32'hDEAD_BEEF);
    chk("ld_late_addr", XLEN'(o_rd_addr), 7);

`ifdef WB_LOAD_ALIGN_EN
    do_load(3, 1, 3'b000, 2, 32'h0080_0000, 0, -1);
    chk("lb_sext", o_rd, 32'hFFFF_FF80);
    do_load(3, 1, 3'b101, 2, 32'h8001_0000, 2, -1);
    chk("lhu_zext", o_rd, 32'h0000_8001);
`endif

    // Timeout then immediate accept
    do_load(4, 1, 3'b010, 0, 32'hAAAA_5555, T + 5, -1);
    do_alu(6, 32'h0000_0042, 1, 0);
    chk("after_to_rd", o_rd, 32'h0000_0042);

    // Flush beats ack, flush in IDLE, write to x0
    do_load(8, 1, 3'b010, 0, 32'h1111_2222, 2, 2);
    do_load(8, 1, 3'b010, 0, 32'h1111_2222, T, T);
    do_alu(9, 32'h9999_9999, 1, 1);
    do_alu(0, 32'h0BAD_F00D, 1, 0);
    chk("x0_ce", XLEN'(o_ce), 1);
    chk("x0_wr", XLEN'(o_wr_en), 0);

    // Reset in WAIT drops the pending load
    i_ce = 1; i_opcode_load = 1; i_wr_en = 1; i_rd_addr = 10; i_mem_ack = 0;
    step(); idle_in(); step();
    chk("pre_rst_stall", XLEN'(o_stall), 1);
    #2 i_rst = 1;
    #1 chk_reset_vals("mid_rst");
    step();
    i_rst = 0;
    i_mem_ack = 1; i_mem_loaded = 32'hCAFE_CAFE;
    step(); idle_in(); step();
    chk_reset_vals("post_rst");

    // Randomized mix
    for (int n = 0; n < 300; n++) begin
      logic [REG_AW-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? '0 : REG_AW'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        do_alu(a, $urandom, 1'($urandom), $urandom_range(0, 7) == 0);
      end else begin
        logic [2:0] f3;
        logic [1:0] lsb;
        int fk;
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
        if (f3 == 3'b010) lsb = 2'd0;
        else if (f3[0]) lsb = {1'($urandom), 1'b0};
        else lsb = 2'($urandom);
        fk = ($urandom_range(0, 5) == 0) ? $urandom_range(0, T) : -1;
        do_load(a, 1'($urandom), f3, lsb, $urandom, $urandom_range(0, T + 2), fk);
      end
      if ($urandom_range(0, 3) == 0) step();
    end

    step(); step();
    chk("sb_empty", XLEN'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_pipe.md
WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32, register and data width.
REQ-002 SHALL provide parameter REG_AW, default 5, register address width.
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 15, the maximum number of cycles to wait for a load acknowledge (minimum 1).
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports:
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  asynchronous active-high reset.
- i_ce  in  1  upstream instruction valid.
- i_wr_en  in  1  instruction writes the register file.
- i_rd_addr  in  REG_AW  destination register.
- i_rd  in  XLEN  ALU result.
- i_opcode_load  in  1  instruction is a load.
- i_funct3  in  3  load size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- i_addr_lsb  in  2  byte offset of the load address.
- i_mem_ack  in  1  load data valid.
- i_mem_loaded  in  XLEN  raw load word.
- i_flush  in  1  kill the in-flight instruction.
- o_stall  out  1  upstream must hold.
- o_wr_en  out  1  register-file write strobe.
- o_rd_addr  out  REG_AW  write address.
- o_rd  out  XLEN  write data.
- o_ce  out  1  instruction retired pulse.
- o_err  out  1  load timeout pulse.

Function
REQ-005 SHALL implement FSM states IDLE and WAIT; o_stall = (state == WAIT), driven from the state register only.
REQ-006 In IDLE, when i_ce=1, i_flush=0 and i_opcode_load=0, the next cycle SHALL output o_ce=1, o_rd=i_rd, o_rd_addr=i_rd_addr, and o_wr_en=i_wr_en && (i_rd_addr != 0).
REQ-007 In IDLE, when i_ce=1, i_flush=0, i_opcode_load=1 and i_mem_ack=1, the next cycle SHALL commit the formatted i_mem_loaded, with the same o_wr_en and o_ce rules as REQ-006.
REQ-008 In IDLE, when i_ce=1, i_flush=0, i_opcode_load=1 and i_mem_ack=0, the block SHALL capture rd_addr, wr_en, funct3 and addr_lsb, clear the timeout counter, and enter WAIT.
REQ-009 In WAIT, i_ce SHALL be ignored, and the counter SHALL increment each cycle that i_mem_ack=0.
REQ-010 In WAIT, i_mem_ack=1 SHALL commit the captured load on the next cycle (o_ce=1, o_wr_en per the captured values) and return the FSM to IDLE.
REQ-011 In WAIT, when the counter reaches TIMEOUT_CYC-1 with no ack, the next cycle SHALL produce o_err=1 and o_ce=0 with no write, and the FSM SHALL return to IDLE.
REQ-012 i_flush=1 SHALL suppress the commit in any state, and in WAIT SHALL return the FSM to IDLE; flush beats a simultaneous i_mem_ack or timeout.
REQ-013 o_wr_en, o_ce and o_err SHALL be single-cycle pulses; o_rd and o_rd_addr SHALL hold their last committed values otherwise.
REQ-014 Latency SHALL be exactly one cycle from accept (non-load) or ack (load) to o_wr_en.
REQ-015 Writes to register 0 SHALL never assert o_wr_en, but SHALL still assert o_ce.

Reset
REQ-016 i_rst=1 SHALL immediately force state IDLE, counter 0, and o_wr_en=o_ce=o_err=0, o_rd=0, o_rd_addr=0, o_stall=0.
REQ-017 Reset asserted during WAIT SHALL drop the pending load with no write after reset release.

Configuration
REQ-018 Macro WB_LOAD_ALIGN_EN defined: loads SHALL select the byte or halfword by i_addr_lsb and sign-extend or zero-extend it per i_funct3 to XLEN.
REQ-019 Macro WB_LOAD_ALIGN_EN undefined: o_rd SHALL equal i_mem_loaded unchanged for every load, and i_funct3 and i_addr_lsb SHALL be unused.

Verification
REQ-020 ALU op: i_ce=1, i_rd_addr=5, i_rd=0x1234_5678, i_wr_en=1 -> one cycle later o_wr_en=1, o_rd_addr=5, o_rd=0x1234_5678, o_ce=1.
REQ-021 Load with ack 3 cycles late: rd_addr=7, then i_mem_ack=1 with loaded=0xDEAD_BEEF -> o_stall high for 3 cycles, write of 0xDEAD_BEEF to register 7 on the cycle after ack.
REQ-022 WB_LOAD_ALIGN_EN defined: LB with lsb=2 and loaded=0x0080_0000 -> o_rd=0xFFFF_FF80; LHU with lsb=2 and loaded=0x8001_0000 -> o_rd=0x0000_8001.
REQ-023 Timeout: load with no ack, TIMEOUT_CYC=15 -> o_err pulse once, no o_wr_en, o_stall drops, next i_ce is accepted.
REQ-024 Flush and ack in the same WAIT cycle -> no o_wr_en and no o_ce, FSM returns to IDLE; write to x0 -> o_ce=1, o_wr_en=0.
REQ-025 i_rst pulsed mid-WAIT, then ack -> no write, all outputs at reset values.
